fpm_pipe: RTL and testbench
===========================

Name: fpm_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point multiplier. Successor to the fixed single-precision multiplier.
- Adds: configurable exponent/mantissa widths, valid/ready handshake with backpressure, round-to-nearest-even, special-value handling, status flags and a pass-through tag.
- Sits in the FPU execute path. Accepts one operation per cycle; results return in order.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1).
- MAN_W, 23, stored fraction width (hidden bit not stored).
- TAG_W, 4, width of opaque tag carried alongside each operation.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- in_x  input  EXP_W+MAN_W+1  operand X {sign, exp, frac}.
- in_y  input  EXP_W+MAN_W+1  operand Y.
- in_tag  input  TAG_W  tag, returned unchanged with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_z  output  EXP_W+MAN_W+1  product.
- out_tag  output  TAG_W  tag of this result.
- out_flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Pipeline and handshake:
  - 3 stages: S1 unpack/classify/exponent add; S2 mantissa product (MAN_W+1)x(MAN_W+1); S3 normalise/round/pack into output registers.
  - Single advance enable: adv = out_ready | ~out_valid. in_ready = adv (combinational, no dependency on in_valid).
  - Transfer in when in_valid & in_ready. Transfer out when out_valid & out_ready.
  - On adv, every stage's valid bit and payload shift forward. A bubble (valid=0) propagates as a bubble.
  - When adv=0, all stages hold. out_z, out_tag and out_flags stay stable while out_valid=1 and out_ready=0.
  - Latency is exactly 3 cycles with out_ready held high. Throughput is 1 op per cycle. No reordering, loss or duplication.
- Reset:
  - rst_n=0 at a clock edge clears all stage valid bits, out_valid=0, out_z=0, out_tag=0, out_flags=0.
  - Reset mid-operation discards all in-flight ops.
  - in_ready=1 in the first cycle after reset releases.
- Arithmetic:
  - Sign = sx ^ sy for all non-NaN results.
  - Inputs with exp=0 are treated as zero (denormals flushed, sign kept).
  - Exponent is computed in EXP_W+2-bit signed form: e = ex + ey - bias.
  - Product is 2*MAN_W+2 bits. If the MSB is set, take the upper bits and e += 1.
  - Guard bit = first bit below the retained fraction. Sticky = OR of all remaining lower bits.
  - Round to nearest even: increment when guard & (sticky | lsb).
  - Rounding carry-out renormalises: fraction becomes 0 and e += 1.
  - inexact = guard | sticky, for finite non-zero results only.
- Special cases (priority order):
  1. Any NaN input, or inf x 0: result is canonical qNaN (sign 0, exp all-ones, frac MSB 1, rest 0). invalid=1 for inf x 0 and for signalling NaN inputs (frac MSB 0).
  2. Any inf operand: result is signed inf, no flags.
  3. Any zero operand: result is signed zero, no flags.
  4. After rounding, e >= 2^EXP_W-1: result is signed inf, overflow=1, inexact=1.
  5. After rounding, e <= 0: result is signed zero, underflow=1, inexact=1.
- Flags belong to their own result. They are not sticky across results.

Decomposition:
- Shared package fpu_pkg holds:
  - bias function of EXP_W;
  - field-extract helpers;
  - canonical qNaN / inf constant functions;
  - flag bit index constants (FLG_INV=3, FLG_OVF=2, FLG_UDF=1, FLG_INX=0).
- One sub-module, fpm_mant_mul:
  - parametrised (MAN_W+1)-bit unsigned multiplier with a registered output and an enable input driven by adv;
  - forms stage S2;
  - can be replaced by the Wallace-tree multiplier without changing the handshake.

Test Plan (EXP_W=8, MAN_W=23 unless noted):
- Basic products, out_ready=1:
  - 0x3FC00000 x 0x40000000 -> 0x40400000, flags 0, result 3 cycles after acceptance.
  - 0xC0400000 x 0x40400000 -> 0xC1100000.
- Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002, inexact=1.
  - 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE, inexact=1 (checks the normalise path).
- Specials:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000, invalid=1.
  - 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1, inexact=1.
  - 0x00800000 x 0x00800000 -> 0x00000000, underflow=1.
  - 0x80000000 x 0x3F800000 -> 0x80000000.
- Backpressure:
  - Issue 5 back-to-back ops, hold out_ready=0 for 6 cycles.
  - in_ready drops once the pipe is full; out_z stays stable; releasing out_ready gives all 5 results in order with tags 0..4.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 ops in flight -> no out_valid for those ops; a new op issued after reset returns correctly 3 cycles later.
- Parameter sweep EXP_W=5, MAN_W=10: 0x3E00 x 0x4000 -> 0x4200; 0x7800 x 0x7800 -> 0x7C00, overflow=1.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: format helpers, special-value constants and flag positions.
// Constant helpers return 64-bit patterns; callers slice them to their own format width.
package fpu_pkg;

    localparam int unsigned FLG_INV = 3;
    localparam int unsigned FLG_OVF = 2;
    localparam int unsigned FLG_UDF = 1;
    localparam int unsigned FLG_INX = 0;

    typedef enum logic [1:0] {KindNorm, KindZero, KindInf, KindNan} kind_e;

    function automatic int unsigned bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    function automatic int unsigned sign_pos(input int unsigned exp_w, input int unsigned man_w);
        return exp_w + man_w;
    endfunction

    function automatic int unsigned exp_lsb(input int unsigned man_w);
        return man_w;
    endfunction

    function automatic logic [63:0] inf_bits(input int unsigned exp_w, input int unsigned man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    function automatic logic [63:0] qnan_bits(input int unsigned exp_w, input int unsigned man_w);
        return inf_bits(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fpm_mant_mul.sv
// Registered unsigned mantissa multiplier; holds its result while en_i is low.
module fpm_mant_mul #(
    parameter int unsigned WIDTH = 24
) (
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic [WIDTH-1:0]       a_i,
    input  logic [WIDTH-1:0]       b_i,
    output logic [2*WIDTH-1:0]     p_o
);

    logic [2*WIDTH-1:0] p_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            p_q <= {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/fpm_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control,
// round-to-nearest-even, flush-to-zero inputs and per-result status flags.
module fpm_pipe import fpu_pkg::*; #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23,
    parameter int unsigned TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [EXP_W+MAN_W:0]     in_x,
    input  logic [EXP_W+MAN_W:0]     in_y,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_z,
    output logic [TAG_W-1:0]         out_tag,
    output logic [3:0]               out_flags
);

    localparam int unsigned W      = EXP_W + MAN_W + 1;
    localparam int unsigned EW2    = EXP_W + 2;
    localparam int unsigned MW1    = MAN_W + 1;
    localparam int unsigned PW     = 2 * MW1;
    localparam int unsigned SgnPos = sign_pos(EXP_W, MAN_W);
    localparam int unsigned ExpLsb = exp_lsb(MAN_W);
    localparam logic [63:0] InfFull  = inf_bits(EXP_W, MAN_W);
    localparam logic [63:0] QnanFull = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-1:0] InfZ  = InfFull[W-1:0];
    localparam logic [W-1:0] QnanZ = QnanFull[W-1:0];
    localparam logic signed [EW2-1:0] BiasE   = EW2'(bias(EXP_W));
    localparam logic signed [EW2-1:0] ExpMaxE = EW2'((1 << EXP_W) - 1);

    logic adv;
    logic out_valid_q;
    logic [W-1:0] out_z_q, z_d;
    logic [TAG_W-1:0] out_tag_q;
    logic [3:0] out_flags_q, flags_d;

    // One global enable: everything moves unless a finished result is blocked.
    assign adv      = out_ready | ~out_valid_q;
    assign in_ready = adv;

    // S1: unpack, classify, exponent sum
    logic sx, sy;
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] fx, fy;
    logic nan_x, nan_y, inf_x, inf_y, zero_x, zero_y, inf_zero;
    kind_e kind_d;
    logic inv_d;
    logic signed [EW2-1:0] e1_d;

    assign sx = in_x[SgnPos];
    assign sy = in_y[SgnPos];
    assign ex = in_x[ExpLsb +: EXP_W];
    assign ey = in_y[ExpLsb +: EXP_W];
    assign fx = in_x[MAN_W-1:0];
    assign fy = in_y[MAN_W-1:0];

    always_comb begin
        nan_x    = (&ex) & (|fx);
        nan_y    = (&ey) & (|fy);
        inf_x    = (&ex) & ~(|fx);
        inf_y    = (&ey) & ~(|fy);
        zero_x   = ~(|ex);
        zero_y   = ~(|ey);
        inf_zero = (inf_x & zero_y) | (zero_x & inf_y);
        inv_d    = 1'b0;
        if (nan_x | nan_y | inf_zero) begin
            kind_d = KindNan;
            inv_d  = inf_zero | (nan_x & ~fx[MAN_W-1]) | (nan_y & ~fy[MAN_W-1]);
        end else if (inf_x | inf_y) begin
            kind_d = KindInf;
        end else if (zero_x | zero_y) begin
            kind_d = KindZero;
        end else begin
            kind_d = KindNorm;
        end
        e1_d = EW2'(ex) + EW2'(ey) - BiasE;
    end

    logic v1_q, sgn1_q, inv1_q;
    kind_e kind1_q;
    logic [TAG_W-1:0] tag1_q;
    logic signed [EW2-1:0] e1_q;
    logic [MAN_W:0] ma1_q, mb1_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
        end else if (adv) begin
            v1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            tag1_q  <= in_tag;
            sgn1_q  <= sx ^ sy;
            kind1_q <= kind_d;
            inv1_q  <= inv_d;
            e1_q    <= e1_d;
            ma1_q   <= {1'b1, fx};
            mb1_q   <= {1'b1, fy};
        end
    end

    // S2: mantissa product, side-band fields travel alongside
    logic [PW-1:0] prod;
    logic v2_q, sgn2_q, inv2_q;
    kind_e kind2_q;
    logic [TAG_W-1:0] tag2_q;
    logic signed [EW2-1:0] e2_q;

    fpm_mant_mul #(
        .WIDTH (MW1)
    ) u_mant_mul (
        .clk_i (clk),
        .en_i  (adv),
        .a_i   (ma1_q),
        .b_i   (mb1_q),
        .p_o   (prod)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
        end else if (adv) begin
            v2_q <= v1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            tag2_q  <= tag1_q;
            sgn2_q  <= sgn1_q;
            kind2_q <= kind1_q;
            inv2_q  <= inv1_q;
            e2_q    <= e1_q;
        end
    end

    // S3: normalise, round, pack
    logic [PW-2:0] norm;
    logic [MAN_W-1:0] frac, frac_r;
    logic guard, sticky, inc, carry;
    logic signed [EW2-1:0] e_fin;

    always_comb begin
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        frac   = norm[PW-2 -: MAN_W];
        guard  = norm[MAN_W];
        sticky = |norm[MAN_W-1:0];
        inc    = guard & (sticky | frac[0]);
        {carry, frac_r} = {1'b0, frac} + MW1'(inc);
        e_fin  = e2_q + EW2'(prod[PW-1]) + EW2'(carry);
    end

    always_comb begin
        z_d     = '0;
        flags_d = '0;
        unique case (kind2_q)
            KindNan: begin
                z_d              = QnanZ;
                flags_d[FLG_INV] = inv2_q;
            end
            KindInf:  z_d = {sgn2_q, InfZ[W-2:0]};
            KindZero: z_d = {sgn2_q, {(W-1){1'b0}}};
            KindNorm: begin
                if (!e_fin[EW2-1] && (e_fin >= ExpMaxE)) begin
                    z_d              = {sgn2_q, InfZ[W-2:0]};
                    flags_d[FLG_OVF] = 1'b1;
                    flags_d[FLG_INX] = 1'b1;
                end else if (e_fin[EW2-1] || (e_fin == '0)) begin
                    z_d              = {sgn2_q, {(W-1){1'b0}}};
                    flags_d[FLG_UDF] = 1'b1;
                    flags_d[FLG_INX] = 1'b1;
                end else begin
                    z_d              = {sgn2_q, e_fin[EXP_W-1:0], frac_r};
                    flags_d[FLG_INX] = guard | sticky;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
        end else if (adv) begin
            out_valid_q <= v2_q;
            out_z_q     <= z_d;
            out_tag_q   <= tag2_q;
            out_flags_q <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fpm_pipe.sv
// Bench for fpm_pipe: directed products, backpressure, mid-stream reset, random
// traffic against a scoreboard fed by an arithmetic model, and a half-precision instance.
module tb_fpm_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_x, in_y, out_z;
    logic [3:0] in_tag, out_tag, out_flags;

    logic v16, r16, ov16;
    logic [15:0] x16, y16, z16;
    logic [3:0] tg16, t16, f16;

    int total = 0;
    int bad = 0;
    int n_out = 0;

    typedef struct packed {
        logic [31:0] z;
        logic [3:0]  f;
        logic [3:0]  tag;
    } exp_t;
    exp_t sb[$];

    fpm_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .out_tag   (out_tag),
        .out_flags (out_flags)
    );

    fpm_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v16),
        .in_ready  (r16),
        .in_x      (x16),
        .in_y      (y16),
        .in_tag    (tg16),
        .out_valid (ov16),
        .out_ready (1'b1),
        .out_z     (z16),
        .out_tag   (t16),
        .out_flags (f16)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Exact integer product, then round by comparing the discarded remainder with one half.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] z, output logic [3:0] f);
        logic [7:0] ex, ey;
        logic [22:0] fx, fy;
        logic s, nx, ny, ix, iy, zx, zy;
        longint unsigned p, q, rem, half;
        int e, sh;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        s  = x[31] ^ y[31];
        nx = (ex == 8'hFF) && (fx != 0);
        ny = (ey == 8'hFF) && (fy != 0);
        ix = (ex == 8'hFF) && (fx == 0);
        iy = (ey == 8'hFF) && (fy == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        f  = 4'b0000;
        if (nx || ny || (ix && zy) || (zx && iy)) begin
            z    = 32'h7FC0_0000;
            f[3] = (nx && !fx[22]) || (ny && !fy[22]) || (ix && zy) || (zx && iy);
        end else if (ix || iy) begin
            z = {s, 8'hFF, 23'h0};
        end else if (zx || zy) begin
            z = {s, 31'h0};
        end else begin
            p  = {40'b0, 1'b1, fx} * {40'b0, 1'b1, fy};
            e  = int'(ex) + int'(ey) - 127;
            sh = (p >= 64'h8000_0000_0000) ? 24 : 23;
            if (sh == 24) e++;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == 64'h100_0000) begin
                q = q >> 1;
                e++;
            end
            if (e >= 255) begin
                z = {s, 8'hFF, 23'h0};
                f = 4'b0101;
            end else if (e <= 0) begin
                z = {s, 31'h0};
                f = 4'b0011;
            end else begin
                z    = {s, 8'(e), q[22:0]};
                f[0] = (rem != 0);
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        logic [7:0] e;
        logic [22:0] f;
        s = 1'($urandom);
        f = 23'($urandom);
        case ($urandom_range(0, 15))
            0: begin e = 8'h00; f = 23'h0; end
            1: begin e = 8'hFF; f = 23'h0; end
            2: begin e = 8'hFF; f[22] = 1'b1; end
            3: begin e = 8'hFF; f[22] = 1'b0; f[0] = 1'b1; end
            4: e = 8'($urandom_range(1, 40));
            5: e = 8'($urandom_range(200, 254));
            6: e = 8'h00;
            7: begin e = 8'($urandom_range(100, 150)); f = 23'h7FFFFF ^ 23'($urandom_range(0, 7)); end
            default: e = 8'($urandom_range(64, 190));
        endcase
        return {s, e, f};
    endfunction

    // Single compare process: scoreboard, ordering, and hold-stability under backpressure.
    initial begin
        exp_t e;
        logic [31:0] mz;
        logic [3:0] mf;
        logic hold = 1'b0;
        logic [31:0] z_h = '0;
        logic [3:0] f_h = '0, t_h = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_z", out_z, z_h);
                    chk("hold_tag", out_tag, t_h);
                    chk("hold_flags", out_flags, f_h);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_out actual=valid z=%h required=no result", out_z);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_z", out_z, e.z);
                        chk("sb_flags", out_flags, e.f);
                        chk("sb_tag", out_tag, e.tag);
                        n_out++;
                    end
                end
                if (in_valid && in_ready) begin
                    model(in_x, in_y, mz, mf);
                    sb.push_back('{z: mz, f: mf, tag: in_tag});
                end
                hold = out_valid && !out_ready;
                z_h = out_z;
                f_h = out_flags;
                t_h = out_tag;
            end
        end
    end

    task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic [3:0] t);
        int n = 0;
        in_x = x; in_y = y; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", in_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic directed(input logic [31:0] x, input logic [31:0] y, input logic [31:0] zr,
                            input logic [3:0] fr, input logic [3:0] t, input string name);
        logic [31:0] mz;
        logic [3:0] mf;
        int lat;
        model(x, y, mz, mf);
        chk({name, "_model_z"}, mz, zr);
        chk({name, "_model_f"}, mf, fr);
        in_x = x; in_y = y; in_tag = t; in_valid = 1'b1;
        @(negedge clk);
        chk({name, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        chk({name, "_lat"}, lat, 3);
        chk({name, "_z"}, out_z, zr);
        chk({name, "_f"}, out_flags, fr);
        chk({name, "_tag"}, out_tag, t);
        @(posedge clk); #1;
    endtask

    task automatic dir16(input logic [15:0] x, input logic [15:0] y, input logic [15:0] zr,
                         input logic [3:0] fr, input string name);
        x16 = x; y16 = y; tg16 = 4'd7; v16 = 1'b1;
        @(posedge clk); #1;
        v16 = 1'b0;
        repeat (3) @(negedge clk);
        chk({name, "_v"}, ov16, 1);
        chk({name, "_z"}, z16, zr);
        chk({name, "_f"}, f16, fr);
        chk({name, "_tag"}, t16, 7);
        @(posedge clk); #1;
    endtask

    initial begin
        int n0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_x = '0; in_y = '0; in_tag = '0;
        v16 = 1'b0; x16 = '0; y16 = '0; tg16 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_z", out_z, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_flags", out_flags, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        directed(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 4'd1, "mul_1p5x2");
        directed(32'hC0400000, 32'h40400000, 32'hC1100000, 4'b0000, 4'd2, "mul_neg3x3");
        directed(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 4'd3, "rnd_small");
        directed(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 4'd4, "rnd_norm");
        directed(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 4'd5, "inf_x_zero");
        directed(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 4'd6, "overflow");
        directed(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 4'd7, "underflow");
        directed(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 4'd8, "neg_zero");
        directed(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 4'd9, "snan");
        directed(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 4'd10, "neg_inf");

        // Backpressure: five ops while the consumer stalls for six cycles.
        out_ready = 1'b0;
        n0 = n_out;
        fork
            begin
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", in_ready, 0);
                chk("bp_out_valid", out_valid, 1);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join_none
        for (int t = 0; t < 5; t++) drive_op(rand_op(), rand_op(), 4'(t));
        in_valid = 1'b0;
        drain();
        chk("bp_count", n_out - n0, 5);

        // Mid-stream reset with a full pipe.
        out_ready = 1'b0;
        for (int t = 0; t < 3; t++) drive_op(32'h40000000, 32'h40400000, 4'(8 + t));
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        @(negedge clk);
        chk("mrst_z", out_z, 0);
        chk("mrst_in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("mrst_no_valid", out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        directed(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 4'd12, "post_rst");
        chk("mrst_outputs", n_out - n0, 1);

        // Random traffic with random backpressure.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_x      = rand_op();
            in_y      = rand_op();
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        dir16(16'h3E00, 16'h4000, 16'h4200, 4'b0000, "h_1p5x2");
        dir16(16'h7800, 16'h7800, 16'h7C00, 4'b0101, "h_overflow");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
